// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the fetch stage
package fetch_pkg;

    localparam int          ENTRY_XLEN  = 32;
    localparam int          INSTR_BYTES = 4;
    localparam logic [31:0] NOP         = 32'h0000_0013;

    typedef struct packed {
        logic [ENTRY_XLEN-1:0] pc;
        logic [31:0]           instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_stage_if.sv
// rtl/fetch_queue_stage_if.sv - redirect, predictor, imem and decode signals of the fetch stage
interface fetch_queue_stage_if #(
    parameter int XLEN = 32
);
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            predict_valid;
    logic [XLEN-1:0] predict_pc;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [31:0]     imem_resp_data;
    logic            instr_valid;
    logic            instr_ready;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;

    // master is the fetch stage itself; slave is the surrounding pipeline and memory
    modport master (
        input  redirect_valid, redirect_pc, predict_valid, predict_pc,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, instr_ready,
        output imem_req_valid, imem_req_addr, instr_valid, instr, pc
    );

    modport slave (
        output redirect_valid, redirect_pc, predict_valid, predict_pc,
        output imem_req_ready, imem_resp_valid, imem_resp_data, instr_ready,
        input  imem_req_valid, imem_req_addr, instr_valid, instr, pc
    );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small synchronous FIFO with flush, used for the instruction queue and tag FIFO
module fetch_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // a pop frees the slot a simultaneous push lands in, even when full
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fetch_queue_stage.sv
// rtl/fetch_queue_stage.sv - fetch PC generation, credit-limited imem requests and instruction queue
module fetch_queue_stage
    import fetch_pkg::*;
#(
    parameter int              XLEN            = 32,
    parameter logic [XLEN-1:0] RESET_PC        = '0,
    parameter int              DEPTH           = 4,
    parameter int              MAX_OUTSTANDING = 2
) (
    input logic                 clk,
    input logic                 reset,
    fetch_queue_stage_if.master bus
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(DEPTH + MAX_OUTSTANDING + 1);

    if (XLEN != ENTRY_XLEN) begin : g_xlen_check
        $error("fetch_queue_stage: XLEN must equal the fetch_entry_t pc width");
    end

    logic [XLEN-1:0] fetch_pc;
    logic [OW-1:0]   outstanding;
    logic [OW-1:0]   drop_cnt;
    logic [SW-1:0]   occupancy;
    logic            req_valid;
    logic            req_fire;
    logic            resp_ok;
    logic            resp_keep;
    logic            instr_valid;

    fetch_entry_t    q_head;
    logic [CW-1:0]   q_count;
    logic            q_full;
    logic            q_empty;
    logic            q_pop;

    logic [XLEN-1:0] tag_head;
    logic [OW-1:0]   tag_count;
    logic            tag_full;
    logic            tag_empty;

    function automatic logic [XLEN-1:0] align(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

    // responses already owed to the queue count against its capacity, so it never overflows
    assign occupancy   = SW'(q_count) + SW'(outstanding);
    assign req_valid   = !reset && !bus.redirect_valid
                         && (outstanding < OW'(MAX_OUTSTANDING))
                         && (occupancy < SW'(DEPTH));
    assign req_fire    = req_valid && bus.imem_req_ready;
    assign resp_ok     = bus.imem_resp_valid && (outstanding != '0);
    assign resp_keep   = resp_ok && (drop_cnt == '0) && !bus.redirect_valid;
    assign instr_valid = !reset && !q_empty && !bus.redirect_valid;
    assign q_pop       = instr_valid && bus.instr_ready;

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = align(fetch_pc);
    assign bus.instr_valid    = instr_valid;
    assign bus.instr          = q_empty ? '0 : q_head.instr;
    assign bus.pc             = q_empty ? '0 : q_head.pc;

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_instr_queue (
        .clk   (clk),
        .reset (reset),
        .push  (resp_keep),
        .pop   (q_pop),
        .flush (bus.redirect_valid),
        .wdata ({tag_head, bus.imem_resp_data}),
        .rdata (q_head),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (req_fire),
        .pop   (resp_keep),
        .flush (bus.redirect_valid),
        .wdata (align(fetch_pc)),
        .rdata (tag_head),
        .full  (tag_full),
        .empty (tag_empty),
        .count (tag_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + OW'(req_fire) - OW'(resp_ok);
            if (bus.redirect_valid) begin
                fetch_pc <= align(bus.redirect_pc);
                drop_cnt <= outstanding - OW'(resp_ok);
            end else begin
                if (req_fire) begin
                    fetch_pc <= bus.predict_valid ? align(bus.predict_pc)
                                                  : fetch_pc + XLEN'(INSTR_BYTES);
                end
                if (resp_ok && (drop_cnt != '0)) drop_cnt <= drop_cnt - OW'(1);
            end
        end
    end

    a_resp_has_request: assert property (@(posedge clk) disable iff (reset)
        bus.imem_resp_valid |-> (outstanding != '0));
    a_queue_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(q_full && resp_keep && !q_pop));
    a_tag_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(tag_full && req_fire));
    a_tag_present: assert property (@(posedge clk) disable iff (reset)
        !(resp_keep && tag_empty));
    // live tags plus responses still to be dropped account for every outstanding request
    a_tag_accounting: assert property (@(posedge clk) disable iff (reset)
        (tag_count + drop_cnt) == outstanding);

endmodule

// File: tb/tb_fetch_queue_stage.sv
// tb/tb_fetch_queue_stage.sv - randomized bench for fetch_queue_stage against a queue-based reference model
module tb_fetch_queue_stage;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam int          MAXO     = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fetch_queue_stage_if #(.XLEN(XLEN)) bus ();

    fetch_queue_stage #(
        .XLEN            (XLEN),
        .RESET_PC        (RESET_PC),
        .DEPTH           (DEPTH),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          squashed;
    } flight_t;

    flight_t     inflight[$];
    logic [31:0] readyq[$];
    logic [31:0] m_pc;
    int          cyc;
    int          checks;
    int          failures;

    function automatic logic [31:0] align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        inflight.delete();
        readyq.delete();
        m_pc = RESET_PC;
    endtask

    task automatic quiet_inputs();
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = '0;
        bus.predict_valid   = 1'b0;
        bus.predict_pc      = '0;
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        bus.instr_ready     = 1'b0;
    endtask

    // one clock: drive random inputs, compare outputs with the model, then advance the model
    task automatic step(input int p_redir, input int p_pred, input int p_rdy,
                        input int p_irdy, input int max_lat);
        bit      redir, pred, resp, exp_rv, exp_iv, fire, pop;
        flight_t r;
        @(negedge clk);
        redir = ($urandom_range(99) < p_redir);
        pred  = ($urandom_range(99) < p_pred);
        resp  = (inflight.size() > 0) && (inflight[0].due <= cyc);
        bus.redirect_valid  = redir;
        bus.redirect_pc     = $urandom() & 32'h0000_03FF;
        bus.predict_valid   = pred;
        bus.predict_pc      = $urandom() & 32'h0000_03FF;
        bus.imem_req_ready  = ($urandom_range(99) < p_rdy);
        bus.instr_ready     = ($urandom_range(99) < p_irdy);
        bus.imem_resp_valid = resp;
        bus.imem_resp_data  = resp ? mem_word(inflight[0].addr) : $urandom();
        #1;
        exp_rv = !redir && (inflight.size() < MAXO) && (readyq.size() + inflight.size() < DEPTH);
        exp_iv = !redir && (readyq.size() != 0);
        check_eq("imem_req_valid", 64'(bus.imem_req_valid), 64'(exp_rv));
        check_eq("imem_req_addr", 64'(bus.imem_req_addr), 64'(m_pc));
        check_eq("instr_valid", 64'(bus.instr_valid), 64'(exp_iv));
        if (exp_iv) begin
            check_eq("head_pc", 64'(bus.pc), 64'(readyq[0]));
            check_eq("head_instr", 64'(bus.instr), 64'(mem_word(readyq[0])));
        end
        fire = exp_rv && bus.imem_req_ready;
        pop  = exp_iv && bus.instr_ready;
        if (pop) void'(readyq.pop_front());
        if (resp) begin
            r = inflight.pop_front();
            if (!redir && !r.squashed) readyq.push_back(r.addr);
        end
        if (redir) begin
            readyq.delete();
            foreach (inflight[i]) inflight[i].squashed = 1'b1;
            m_pc = align(bus.redirect_pc);
        end else if (fire) begin
            inflight.push_back('{addr: m_pc, due: cyc + int'($urandom_range(max_lat, 1)), squashed: 1'b0});
            m_pc = pred ? align(bus.predict_pc) : m_pc + 32'd4;
        end
        cyc++;
    endtask

    task automatic run(input int n, input int p_redir, input int p_pred, input int p_rdy,
                       input int p_irdy, input int max_lat);
        for (int i = 0; i < n; i++) step(p_redir, p_pred, p_rdy, p_irdy, max_lat);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        quiet_inputs();
        model_reset();
        reset = 1'b1;
        #12;
        check_eq("reset_req_valid", 64'(bus.imem_req_valid), 64'd0);
        check_eq("reset_instr_valid", 64'(bus.instr_valid), 64'd0);
        check_eq("reset_instr", 64'(bus.instr), 64'd0);
        check_eq("reset_pc", 64'(bus.pc), 64'd0);
        check_eq("reset_addr", 64'(bus.imem_req_addr), 64'(RESET_PC));
        @(negedge clk);
        reset = 1'b0;

        // streaming, single-cycle memory, decode always ready
        run(40, 0, 0, 100, 100, 1);
        // decode stalls: credits must cap requests, then resume
        run(20, 0, 0, 100, 0, 1);
        run(20, 0, 0, 100, 100, 1);
        // longer latency with redirects and predictions
        run(200, 5, 20, 70, 70, 3);
        // heavy random traffic including back-to-back redirects and long stalls
        run(400, 12, 30, 50, 60, 4);
        run(60, 0, 0, 20, 50, 2);

        // fill the queue, then pulse reset between clock edges
        run(12, 0, 0, 100, 0, 2);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_eq("midreset_req_valid", 64'(bus.imem_req_valid), 64'd0);
        check_eq("midreset_instr_valid", 64'(bus.instr_valid), 64'd0);
        check_eq("midreset_addr", 64'(bus.imem_req_addr), 64'(RESET_PC));
        quiet_inputs();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        run(60, 0, 10, 80, 80, 2);
        run(150, 8, 25, 60, 60, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_queue_stage.md
Name: fetch_queue_stage

Overview:
Parametrised next-generation fetch stage. It generates the fetch PC and issues requests to a pipelined instruction memory that can stall (valid/ready) and answers in order with variable latency. Responses are buffered in a DEPTH-entry instruction queue that feeds decode through a valid/ready handshake. Execute redirects flush the queue and squash in-flight responses; a predictor can steer the next fetch address.

Parameters:
XLEN, 32, width of PC, addresses and instruction words.
RESET_PC, 32'h0000_0000, first fetch address after reset.
DEPTH, 4, instruction queue entries; power of two, >= 2.
MAX_OUTSTANDING, 2, maximum accepted-but-unanswered memory requests; 1 <= MAX_OUTSTANDING <= DEPTH.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
redirect_valid  in  1  execute-stage redirect (mispredict/jump); highest priority
redirect_pc  in  XLEN  redirect target; bits [1:0] ignored (treated as 0)
predict_valid  in  1  predictor says: next fetch after the current request goes to predict_pc
predict_pc  in  XLEN  predicted target; bits [1:0] ignored
imem_req_valid  out  1  request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  word-aligned fetch address
imem_resp_valid  in  1  in-order response strobe
imem_resp_data  in  32  instruction word
instr_valid  out  1  queue head valid toward decode
instr_ready  in  1  decode accepts head
instr  out  32  head instruction
pc  out  XLEN  PC of head instruction

Behaviour:
- Reset (async): fetch_pc=RESET_PC, queue empty, outstanding=0, drop_cnt=0; imem_req_valid=0, instr_valid=0, instr=0, pc=0.
- Credit rule: imem_req_valid = !redirect_valid && (outstanding < MAX_OUTSTANDING) && (count + outstanding < DEPTH). Queue overflow is structurally impossible.
- imem_req_addr = {fetch_pc[XLEN-1:2],2'b00}.
- Request handshake (valid && ready): outstanding+1; the request PC is pushed into the in-flight tag FIFO; fetch_pc <= predict_valid ? predict_pc : fetch_pc+4.
- predict_valid without a handshake that cycle has no effect.
- Response while drop_cnt==0: pop the tag FIFO, push {tag pc, imem_resp_data} into the queue, outstanding-1. Data is visible at the queue head no earlier than the next cycle; there is no bypass.
- Response while drop_cnt>0: discard it, drop_cnt-1, outstanding-1.
- Simultaneous request handshake and response: outstanding unchanged.
- Redirect cycle:
  - fetch_pc <= redirect_pc aligned; queue and tag FIFO flushed.
  - drop_cnt <= outstanding - (imem_resp_valid ? 1 : 0); a response in this same cycle is discarded.
  - instr_valid forced 0 and no pop occurs; no request issues.
- First request to the redirect target is issued in the following cycle, subject to credits.
- Output: instr_valid = (count != 0) && !redirect_valid. Pop on instr_valid && instr_ready. Push and pop in the same cycle are allowed, including when the queue is full.
- Response with outstanding==0 is a protocol violation: ignored, and flagged by a simulation assertion.
- Wrap-around: fetch_pc+4 wraps modulo 2^XLEN. Queue pointers wrap modulo DEPTH.
- Reset asserted mid-operation: all state cleared immediately. Responses from requests issued before reset are the memory's responsibility; the memory is reset together with this block.

Decomposition:
- Package fetch_pkg holds:
  - typedef fetch_entry_t {pc, instr};
  - constants INSTR_BYTES=4 and NOP=32'h0000_0013 (used as the instr value when empty is not required).
- Sub-module fetch_fifo (parametrised WIDTH, DEPTH; push/pop/flush, full/empty/count). It is instantiated twice: as the instruction queue (fetch_entry_t) and as the in-flight tag FIFO (XLEN, depth MAX_OUTSTANDING).

Test Plan:
- Reset release, imem_req_ready=1, 1-cycle memory, instr_ready=1 -> addresses 0x0,0x4,0x8… issued back-to-back; decode receives pc/instr pairs in order, first instr_valid 2 cycles after the first request.
- instr_ready=0 with DEPTH=4, MAX_OUTSTANDING=2 -> exactly 4 requests are accepted, then imem_req_valid=0; count+outstanding never exceeds 4; raising instr_ready resumes at 0x10.
- 3-cycle latency memory, redirect_valid with redirect_pc=0x100 while 2 requests are outstanding -> both responses dropped, queue empty, next request 0x100, first delivered pc=0x100.
- predict_valid with predict_pc=0x40 coincident with the handshake of the request to 0x8 -> sequence 0x8,0x40,0x44; with no handshake that cycle, the prediction is ignored.
- Redirect in the same cycle as a response and a decode pop -> response discarded, no pop, drop_cnt = outstanding-1, instr_valid=0 that cycle.
- imem_req_ready held low for 5 cycles -> imem_req_addr is stable and fetch_pc does not advance; asynchronous reset pulse mid-stream -> instr_valid and imem_req_valid drop to 0 immediately, and fetch restarts at RESET_PC.
